// File: rtl/modem_pkg.sv
// Modem-level constants and the message-feeder state encoding.
package modem_pkg;

   localparam int FEEDER_DEPTH         = 4;
   localparam int FEEDER_GAP_CYCLES    = 2;
   localparam int FEEDER_START_TIMEOUT = 8;
   localparam int FEEDER_CNT_W         = 16;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      GAP        = 3'd4
   } feeder_state_t;

endpackage

// File: rtl/spreading_factors_pkg.sv
// Spreading-factor encoding shared by the DCSK transmitter and its feeders.
package spreading_factors_pkg;

   typedef enum logic [1:0] {
      SF4  = 2'd0,
      SF8  = 2'd1,
      SF16 = 2'd2,
      SF32 = 2'd3
   } sf_t;

endpackage

// File: rtl/dcsk_word_fifo.sv
// Small synchronous FIFO with a read-ahead head word and a registered count.
// A push while full is refused even if a pop happens in the same cycle.
module dcsk_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write; contents need no reset since the count gates every read.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dcsk_tx_feeder.sv
// Buffers upstream (word, sf) pairs and hands them one at a time to the DCSK
// transmitter, with a start watchdog and an enforced inter-message gap.
module dcsk_tx_feeder
   import modem_pkg::*;
   import spreading_factors_pkg::*;
#(
   parameter int DEPTH         = FEEDER_DEPTH,
   parameter int GAP_CYCLES    = FEEDER_GAP_CYCLES,
   parameter int START_TIMEOUT = FEEDER_START_TIMEOUT,
   parameter int CNT_W         = FEEDER_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_word,
   input  sf_t              i_sf,
   output logic             o_send,
   output logic [31:0]      o_msg,
   output sf_t              o_sf,
   input  logic             i_is_sending,
   output logic             o_busy,
   output logic             o_err,
   output logic [CNT_W-1:0] o_sent_cnt,
   output logic [CNT_W-1:0] o_drop_cnt
);

   localparam int SF_W  = $bits(sf_t);
   localparam int FW    = 32 + SF_W;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int TMO_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);
   localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

   feeder_state_t    r_state, w_state_next;
   logic             r_send, w_send_next;
   logic [31:0]      r_msg, w_msg_next;
   sf_t              r_sf, w_sf_next;
   logic             r_err, w_err_next;
   logic [CNT_W-1:0] r_sent, w_sent_next;
   logic [CNT_W-1:0] r_drop, w_drop_next;
   logic [TMO_W-1:0] r_tmo, w_tmo_next;
   logic [GAP_W-1:0] r_gap, w_gap_next;
   logic             r_busy, w_busy_next;

   logic             w_push, w_pop;
   logic             w_full, w_empty;
   logic [FW-1:0]    w_head;
   logic [CW-1:0]    w_count, w_count_next;

   assign o_ready    = !w_full;
   assign w_push     = i_valid && !w_full;
   assign o_send     = r_send;
   assign o_msg      = r_msg;
   assign o_sf       = r_sf;
   assign o_err      = r_err;
   assign o_sent_cnt = r_sent;
   assign o_drop_cnt = r_drop;
   assign o_busy     = r_busy;

   dcsk_word_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  ({i_sf, i_word}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Next-state, watchdog, gap and status-counter logic.
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_send_next  = 1'b0;
      w_err_next   = 1'b0;
      w_msg_next   = r_msg;
      w_sf_next    = r_sf;
      w_tmo_next   = r_tmo;
      w_gap_next   = r_gap;
      w_sent_next  = r_sent;
      w_drop_next  = r_drop;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_msg_next   = w_head[31:0];
               w_sf_next    = sf_t'(w_head[32 +: SF_W]);
               w_send_next  = 1'b1;
               w_state_next = START;
            end
         end
         START: begin
            w_tmo_next   = TMO_W'(START_TIMEOUT);
            w_state_next = WAIT_START;
         end
         WAIT_START: begin
            // A start seen on the expiry edge still wins over the watchdog.
            if (i_is_sending) begin
               w_state_next = WAIT_DONE;
            end else if (r_tmo <= TMO_W'(1)) begin
               w_err_next   = 1'b1;
               w_drop_next  = (r_drop == '1) ? r_drop : r_drop + CNT_W'(1);
               w_gap_next   = GAP_W'(GAP_CYCLES);
               w_state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               w_tmo_next = r_tmo - TMO_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!i_is_sending) begin
               w_sent_next  = (r_sent == '1) ? r_sent : r_sent + CNT_W'(1);
               w_gap_next   = GAP_W'(GAP_CYCLES);
               w_state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (r_gap <= GAP_W'(1)) begin
               w_state_next = IDLE;
            end else begin
               w_gap_next = r_gap - GAP_W'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
      w_count_next = w_count + CW'(w_push) - CW'(w_pop);
      w_busy_next  = (w_state_next != IDLE) || (w_count_next != '0);
   end

   // State and output registers; reset drops any in-flight word uncounted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_send  <= 1'b0;
         r_msg   <= '0;
         r_sf    <= SF4;
         r_err   <= 1'b0;
         r_sent  <= '0;
         r_drop  <= '0;
         r_tmo   <= '0;
         r_gap   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_send  <= w_send_next;
         r_msg   <= w_msg_next;
         r_sf    <= w_sf_next;
         r_err   <= w_err_next;
         r_sent  <= w_sent_next;
         r_drop  <= w_drop_next;
         r_tmo   <= w_tmo_next;
         r_gap   <= w_gap_next;
         r_busy  <= w_busy_next;
      end
   end

endmodule

// File: tb/tb_dcsk_tx_feeder.sv
// Directed and randomized bench for dcsk_tx_feeder with a behavioural tx model.
module tb_dcsk_tx_feeder;
   import spreading_factors_pkg::*;

   localparam int DEPTH = 4;
   localparam int GAP   = 3;
   localparam int TMO   = 8;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_word = '0;
   sf_t         i_sf = SF4;
   logic        o_send;
   logic [31:0] o_msg;
   sf_t         o_sf;
   logic        i_is_sending = 1'b0;
   logic        o_busy;
   logic        o_err;
   logic [15:0] o_sent_cnt;
   logic [15:0] o_drop_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Monitor observations
   int          cyc = 0;
   int          send_cnt = 0;
   int          err_cnt = 0;
   int          last_err_cyc = 0;
   int          last_fall_cyc = 0;
   int          hold_viol = 0;
   bit          hold_chk = 0;
   int          send_cyc_q[$];
   logic [33:0] got_q[$];
   logic [33:0] exp_q[$];
   int          exp_sent = 0;
   int          exp_drop = 0;

   // tx model controls
   bit tx_en = 1;
   bit tx_rand = 0;
   int tx_lat = 2;
   int tx_hold = 10;
   int tx_cd = 0;
   int tx_hl = 0;
   int cur_hold = 0;

   dcsk_tx_feeder #(
      .DEPTH(DEPTH), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO), .CNT_W(16)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_word(i_word), .i_sf(i_sf), .o_send(o_send), .o_msg(o_msg), .o_sf(o_sf),
      .i_is_sending(i_is_sending), .o_busy(o_busy), .o_err(o_err),
      .o_sent_cnt(o_sent_cnt), .o_drop_cnt(o_drop_cnt)
   );

   always #5 clk = ~clk;

   // tx model: raise busy a latency after o_send, hold it, then drop it.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_cd > 0) begin
            tx_cd--;
            if (tx_cd == 0) begin
               i_is_sending = 1'b1;
               tx_hl = cur_hold;
            end
         end else if (i_is_sending) begin
            tx_hl--;
            if (tx_hl <= 0) i_is_sending = 1'b0;
         end
         if (o_send && tx_en) begin
            if (tx_rand) begin
               tx_cd    = $urandom_range(1, 6);
               cur_hold = $urandom_range(1, 8);
            end else begin
               tx_cd    = tx_lat;
               cur_hold = tx_hold;
            end
         end
      end
   end

   // Monitor: sample just after each rising edge.
   initial begin
      logic prev_is;
      logic [31:0] prev_msg;
      prev_is = 1'b0;
      prev_msg = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (o_send === 1'b1) begin
            send_cnt++;
            send_cyc_q.push_back(cyc);
            got_q.push_back({o_sf, o_msg});
         end
         if (o_err === 1'b1) begin
            err_cnt++;
            last_err_cyc = cyc;
         end
         if (prev_is && !i_is_sending) last_fall_cyc = cyc;
         if (hold_chk && prev_is && i_is_sending && (o_msg !== prev_msg)) hold_viol++;
         prev_is  = i_is_sending;
         prev_msg = o_msg;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w, input sf_t s, output bit first);
      int n;
      n = 0;
      first = o_ready;
      i_valid = 1'b1;
      i_word = w;
      i_sf = s;
      while (!o_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         check("push_timeout", 64'(o_ready), 64'(1));
         i_valid = 1'b0;
      end else begin
         @(negedge clk);
         i_valid = 1'b0;
         exp_q.push_back({s, w});
      end
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      while ((o_busy || i_is_sending || tx_cd != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (o_busy || i_is_sending || tx_cd != 0) check(tag, 64'(o_busy), 64'(0));
   endtask

   task automatic wait_sends(input int target, input string tag);
      int n;
      n = 0;
      while (send_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (send_cnt < target) check(tag, 64'(send_cnt), 64'(target));
   endtask

   task automatic wait_errs(input int target, input string tag);
      int n;
      n = 0;
      while (err_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (err_cnt < target) check(tag, 64'(err_cnt), 64'(target));
   endtask

   task automatic sb_compare(input string tag);
      logic [33:0] g;
      check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         check(tag, 64'(g), 64'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      bit first;
      int nfirst, bs, be;
      int e1;

      // Reset and reset values
      repeat (3) @(negedge clk);
      i_rst = 1'b0;
      check("rst_send",  64'(o_send), 64'(0));
      check("rst_msg",   64'(o_msg), 64'(0));
      check("rst_sf",    64'(o_sf), 64'(SF4));
      check("rst_err",   64'(o_err), 64'(0));
      check("rst_sent",  64'(o_sent_cnt), 64'(0));
      check("rst_drop",  64'(o_drop_cnt), 64'(0));
      check("rst_ready", 64'(o_ready), 64'(1));
      check("rst_busy",  64'(o_busy), 64'(0));
      got_q.delete();
      hold_chk = 1;

      // Single word
      bs = send_cnt; be = err_cnt;
      tx_en = 1; tx_lat = 2; tx_hold = 512;
      push(32'hDEADBEEF, SF8, first);
      exp_sent++;
      wait_idle("single_idle", 2000);
      check("single_sends", 64'(send_cnt - bs), 64'(1));
      check("single_msg", 64'(o_msg), 64'(32'hDEADBEEF));
      check("single_sf", 64'(o_sf), 64'(SF8));
      check("single_sent", 64'(o_sent_cnt), 64'(exp_sent));
      check("single_noerr", 64'(err_cnt - be), 64'(0));
      sb_compare("single_sb");

      // Backpressure: one in flight plus DEPTH buffered
      tx_hold = 40;
      nfirst = 0;
      for (int i = 0; i < 5; i++) begin
         push($urandom(), sf_t'($urandom_range(0, 3)), first);
         if (first) nfirst++;
      end
      check("bp_first5", 64'(nfirst), 64'(5));
      check("bp_ready_low", 64'(o_ready), 64'(0));
      push($urandom(), sf_t'($urandom_range(0, 3)), first);
      exp_sent += 6;
      wait_idle("bp_idle", 2000);
      check("bp_sent", 64'(o_sent_cnt), 64'(exp_sent));
      sb_compare("bp_sb");

      // Start timeout, then the next queued word after the gap
      tx_en = 0;
      bs = send_cnt; be = err_cnt;
      push(32'h12345678, SF16, first);
      push(32'hCAFEF00D, SF32, first);
      wait_errs(be + 1, "tmo_err1_wait");
      e1 = last_err_cyc;
      check("tmo_err_delay", 64'(e1 - send_cyc_q[bs]), 64'(TMO + 1));
      wait_sends(bs + 2, "tmo_send2_wait");
      check("tmo_next_send", 64'(send_cyc_q[bs + 1] - e1), 64'(GAP + 1));
      wait_idle("tmo_idle", 2000);
      exp_drop += 2;
      check("tmo_err_pulses", 64'(err_cnt - be), 64'(2));
      check("tmo_drop", 64'(o_drop_cnt), 64'(exp_drop));
      check("tmo_sent", 64'(o_sent_cnt), 64'(exp_sent));
      sb_compare("tmo_sb");

      // Gap enforcement between two queued words
      tx_en = 1; tx_lat = 2; tx_hold = 5;
      bs = send_cnt;
      push($urandom(), SF4, first);
      push($urandom(), SF32, first);
      wait_sends(bs + 2, "gap_send2_wait");
      check("gap_edges", 64'(send_cyc_q[bs + 1] - last_fall_cyc), 64'(GAP + 1));
      wait_idle("gap_idle", 2000);
      exp_sent += 2;
      check("gap_sent", 64'(o_sent_cnt), 64'(exp_sent));
      sb_compare("gap_sb");

      // Reset while the transmitter is busy and three words are buffered
      tx_hold = 60;
      for (int i = 0; i < 4; i++) push($urandom(), sf_t'($urandom_range(0, 3)), first);
      for (int n = 0; n < 100 && !i_is_sending; n++) @(negedge clk);
      repeat (3) @(negedge clk);
      hold_chk = 0;
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      check("mrst_ready", 64'(o_ready), 64'(1));
      check("mrst_busy", 64'(o_busy), 64'(0));
      check("mrst_sent", 64'(o_sent_cnt), 64'(0));
      check("mrst_drop", 64'(o_drop_cnt), 64'(0));
      check("mrst_msg", 64'(o_msg), 64'(0));
      got_q.delete(); exp_q.delete();
      exp_sent = 0; exp_drop = 0;
      bs = send_cnt;
      repeat (30) @(negedge clk);
      check("mrst_no_send", 64'(send_cnt - bs), 64'(0));
      wait_idle("mrst_idle", 2000);
      check("mrst_no_send2", 64'(send_cnt - bs), 64'(0));
      hold_chk = 1;

      // Randomized traffic
      tx_rand = 1;
      be = err_cnt;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
         push($urandom(), sf_t'($urandom_range(0, 3)), first);
      end
      exp_sent += 1000;
      wait_idle("rand_idle", 5000);
      check("rand_sent", 64'(o_sent_cnt), 64'(exp_sent));
      check("rand_drop", 64'(o_drop_cnt), 64'(0));
      check("rand_noerr", 64'(err_cnt - be), 64'(0));
      sb_compare("rand_sb");
      check("msg_hold_while_sending", 64'(hold_viol), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dcsk_tx_feeder.md
# dcsk_tx_feeder

Hardware initiator for the DCSK transmitter's message interface. Upstream logic pushes (32-bit word, spreading factor) pairs through a valid/ready port. The block buffers them and issues them one at a time to `tx` by pulsing `o_send`, holding `o_msg`/`o_sf` stable until `tx` reports the symbol stream finished. It replaces bench-driven `i_send` sequencing in integrated builds and enforces an inter-message gap plus a start-handshake watchdog.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries, power of two, minimum 2.
- `GAP_CYCLES`, default 2: idle cycles enforced between the fall of `i_is_sending` and the next `o_send`; 0 is legal.
- `START_TIMEOUT`, default 8: cycles allowed after `o_send` for `i_is_sending` to rise.
- `CNT_W`, default 16: width of the status counters.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous active-high reset.
- `i_valid`  in  1  upstream word valid.
- `o_ready`  out  1  FIFO can accept.
- `i_word`  in  32  message word.
- `i_sf`  in  `sf_t`  spreading factor for this word (SF4/SF8/SF16/SF32).
- `o_send`  out  1  one-cycle start pulse to `tx`.
- `o_msg`  out  32  word presented to `tx`.
- `o_sf`  out  `sf_t`  spreading factor presented to `tx`.
- `i_is_sending`  in  1  `tx` busy (the `o_is_sending` of `tx`).
- `o_busy`  out  1  FSM not in IDLE, or FIFO not empty.
- `o_err`  out  1  one-cycle pulse on start timeout.
- `o_sent_cnt`  out  `CNT_W`  completed messages, saturating.
- `o_drop_cnt`  out  `CNT_W`  timed-out messages, saturating.

## Operation

- FIFO stores `{sf, word}`. Push when `i_valid && o_ready`. `o_ready = !full`, derived from the registered count only, so a push is refused when the FIFO is full even if a pop occurs in the same cycle. Push and pop in the same cycle while not full leaves the count unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is not empty, pop the head, register `o_msg`/`o_sf`, set `o_send=1`, and go to START.
  - START (1 cycle): clear `o_send`, load the timeout counter with `START_TIMEOUT`, and go to WAIT_START.
  - WAIT_START: if `i_is_sending=1`, go to WAIT_DONE. Otherwise decrement the counter. When it reaches 0, pulse `o_err`, increment `o_drop_cnt`, and go to GAP.
  - WAIT_DONE: when `i_is_sending=0`, increment `o_sent_cnt` and go to GAP.
  - GAP: count `GAP_CYCLES`, then go to IDLE. If `GAP_CYCLES=0`, go to IDLE directly.
- `o_msg`/`o_sf` are held from the pop until the next pop and never change while `i_is_sending=1`.
- Counters saturate at all-ones and never wrap.
- Reset values: `o_send=0`, `o_msg=0`, `o_sf=SF4`, `o_err=0`, both counters 0, `o_ready=1`, `o_busy=0`, FIFO empty, state IDLE.
- Reset mid-operation (any state) flushes the FIFO and drops the in-flight word without counting it. `tx` receives no further `o_send` until new words arrive.

## Timing

- Word accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - `o_send` is high from E1 to E2 (one-cycle latency).
  - `o_msg`/`o_sf` are valid from E1.
- Earliest next `o_send` after `i_is_sending` falls (sampled at edge F): edge F+`GAP_CYCLES`+1.
- Timeout: the `o_err` pulse is high exactly `START_TIMEOUT`+1 cycles after the E1 edge of the `o_send` pulse.
- `i_is_sending` rising on the same edge the counter expires counts as started; the watchdog loses.
- `o_busy` is registered and reflects state/FIFO after each edge.
- Throughput per message is at most one per (3 + `GAP_CYCLES` + `tx` busy duration) cycles.

## Structure

- `feeder_state_t` enum (IDLE, START, WAIT_START, WAIT_DONE, GAP) and the default parameter constants go in `modem_pkg`.
- `sf_t` is reused from `spreading_factors_pkg`; no new encoding.
- One sub-module, `dcsk_word_fifo`: synchronous FIFO, `DEPTH` entries, width 32 + `$bits(sf_t)`. It has registered count, `full`/`empty`, read-ahead head output, and wrap-around pointers of log2(`DEPTH`) bits plus a count.
- The FSM, watchdog, gap counter and status counters live in the top.

## Test plan

- Single word: push 0xDEADBEEF with SF8; `tx` model raises `i_is_sending` 2 cycles after `o_send` and holds it 512 cycles → exactly one `o_send`, `o_msg`=0xDEADBEEF, `o_sf`=SF8, `o_sent_cnt`=1, `o_err` never set.
- Backpressure: `DEPTH`=4, push 6 words back-to-back while `tx` is busy → `o_ready` falls after the 5th accept (one in flight plus 4 buffered). All 6 go out in order, matched against a scoreboard queue; `o_sent_cnt`=6.
- Start timeout: `i_is_sending` tied 0, push 0x12345678 → `o_err` high exactly 9 cycles after `o_send`, `o_drop_cnt`=1, next queued word issued after the gap.
- Gap enforcement: `GAP_CYCLES`=3, two queued words → second `o_send` exactly 4 edges after `i_is_sending` falls.
- Reset mid-WAIT_DONE with 3 words buffered → next cycle: FIFO empty, `o_ready`=1, counters 0, `o_msg`=0. No `o_send` follows until a new push.
- Randomized: 1000 words with random SF, random `tx` latency (1–6 cycles) and 20% random upstream idle bursts → the scoreboard matches every `o_msg`/`o_sf` and `o_sent_cnt`=1000.
